// File: rtl/video_img_pkg.sv
// Shared definitions for the bouncing test-image position controller:
// screen/image defaults, coordinate width and controller state encodings.
package video_img_pkg;

  localparam int COORD_W  = 13;
  localparam int SCRW_DEF = 1920;
  localparam int SCRH_DEF = 1080;
  localparam int IMGW_DEF = 320;
  localparam int IMGH_DEF = 240;

  typedef logic [COORD_W-1:0] coord_t;

  // Frame tracking: wait for start of frame, count lines, one-cycle offset update.
  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_RUN      = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  // One motion axis: current offset plus travel direction (1 = moving toward 0).
  typedef struct packed {
    coord_t pos;
    logic   dir_neg;
  } axis_t;

endpackage

// File: rtl/video_axis_snoop.sv
// Passive AXI-Stream snooper: decodes beats, start-of-frame and end-of-line,
// counts lines of the current frame and flags a start-of-frame arriving mid-frame.
module video_axis_snoop
  import video_img_pkg::*;
#(
  parameter int SCRH = SCRH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic in_run,
  input  logic snp_tvalid,
  input  logic snp_tready,
  input  logic snp_tuser,
  input  logic snp_tlast,
  output logic frame_start,
  output logic frame_done,
  output logic sync_err
);

  localparam coord_t LAST_LINE = coord_t'(SCRH - 1);

  logic   beat;
  logic   sof;
  logic   eol;
  logic   active;
  coord_t base;
  coord_t line_cnt_q;
  coord_t line_cnt_d;
  logic   sync_err_q;
  logic   sync_err_d;

  // Decode handshakes; a SOF always restarts the line count before the same beat's EOL is counted.
  always_comb begin
    beat        = snp_tvalid & snp_tready;
    sof         = beat & snp_tuser;
    eol         = beat & snp_tlast;
    frame_start = in_wait & sof;
    active      = frame_start | in_run;
    sync_err_d  = in_run & sof & (line_cnt_q != '0);
    base        = (active & sof) ? '0 : line_cnt_q;
    frame_done  = active & eol & (base == LAST_LINE);
    line_cnt_d  = line_cnt_q;
    if (active) begin
      if (frame_done) begin
        line_cnt_d = '0;
      end else if (eol) begin
        line_cnt_d = base + coord_t'(1);
      end else begin
        line_cnt_d = base;
      end
    end
  end

  // Line counter and one-cycle resync error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      line_cnt_q <= line_cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;

endmodule

// File: rtl/video_img_pos_ctrl.sv
// Frame-synchronous position controller: moves the test image across the
// screen in steps, bouncing off the edges, updating margins only between frames.
module video_img_pos_ctrl
  import video_img_pkg::*;
#(
  parameter int SCRW      = SCRW_DEF,
  parameter int SCRH      = SCRH_DEF,
  parameter int IMGW      = IMGW_DEF,
  parameter int IMGH      = IMGH_DEF,
  parameter int FRAME_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [3:0]   step_x,
  input  logic [3:0]   step_y,
  input  logic         snp_tvalid,
  input  logic         snp_tready,
  input  logic         snp_tuser,
  input  logic         snp_tlast,
  output logic [12:0]  addw,
  output logic [12:0]  subw,
  output logic [12:0]  addh,
  output logic [12:0]  subh,
  output logic [15:0]  frame_cnt,
  output logic         sync_err
);

  localparam coord_t     LIM_X    = coord_t'(SCRW - IMGW);
  localparam coord_t     LIM_Y    = coord_t'(SCRH - IMGH);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  // Advance one axis by step, clamping at 0 / lim and reversing there.
  // A zero step or a zero-width travel range leaves the axis untouched.
  function automatic axis_t step_axis(input axis_t cur, input logic [3:0] step, input coord_t lim);
    logic [COORD_W:0] nx;
    axis_t            res;
    res = cur;
    nx  = {1'b0, cur.pos} + {{(COORD_W-3){1'b0}}, step};
    if ((step != 4'd0) && (lim != '0)) begin
      if (!cur.dir_neg) begin
        if (nx >= {1'b0, lim}) begin
          res.pos     = lim;
          res.dir_neg = 1'b1;
        end else begin
          res.pos = nx[COORD_W-1:0];
        end
      end else begin
        if (cur.pos <= {{(COORD_W-4){1'b0}}, step}) begin
          res.pos     = '0;
          res.dir_neg = 1'b0;
        end else begin
          res.pos = cur.pos - {{(COORD_W-4){1'b0}}, step};
        end
      end
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  axis_t       ax_q, ax_d;
  axis_t       ay_q, ay_d;
  coord_t      subw_q, subw_d;
  coord_t      subh_q, subh_d;
  logic [15:0] fc_q, fc_d;
  logic [7:0]  div_q, div_d;
  logic        in_wait;
  logic        in_run;
  logic        frame_start;
  logic        frame_done;

  assign in_wait = (state_q == ST_WAIT_SOF);
  assign in_run  = (state_q == ST_RUN);

  video_axis_snoop #(
    .SCRH(SCRH)
  ) u_snoop (
    .clk         (clk),
    .rst         (rst),
    .in_wait     (in_wait),
    .in_run      (in_run),
    .snp_tvalid  (snp_tvalid),
    .snp_tready  (snp_tready),
    .snp_tuser   (snp_tuser),
    .snp_tlast   (snp_tlast),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .sync_err    (sync_err)
  );

  // Frame FSM and motion: position only moves in the single UPDATE cycle.
  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    fc_d    = fc_q;
    div_d   = div_q;
    case (state_q)
      ST_WAIT_SOF: begin
        if (frame_start) begin
          state_d = frame_done ? ST_UPDATE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_WAIT_SOF;
        fc_d    = fc_q + 16'd1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (en) begin
            ax_d = step_axis(ax_q, step_x, LIM_X);
            ay_d = step_axis(ay_q, step_y, LIM_Y);
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_WAIT_SOF;
    endcase
    subw_d = LIM_X - ax_d.pos;
    subh_d = LIM_Y - ay_d.pos;
  end

  // Registered state, position and margins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_SOF;
      ax_q    <= '{pos: '0, dir_neg: 1'b0};
      ay_q    <= '{pos: '0, dir_neg: 1'b0};
      subw_q  <= LIM_X;
      subh_q  <= LIM_Y;
      fc_q    <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      subw_q  <= subw_d;
      subh_q  <= subh_d;
      fc_q    <= fc_d;
      div_q   <= div_d;
    end
  end

  assign addw      = ax_q.pos;
  assign addh      = ay_q.pos;
  assign subw      = subw_q;
  assign subh      = subh_q;
  assign frame_cnt = fc_q;

endmodule

// File: tb/tb_video_img_pos_ctrl.sv
// Bench for the bouncing image position controller on a 64x8 screen with a
// 16x4 image. Frames are driven from a vector table; expected margins are
// queued per frame and compared whenever the DUT outputs change.
module tb_video_img_pos_ctrl;

  localparam int SCRW = 64;
  localparam int SCRH = 8;
  localparam int IMGW = 16;
  localparam int IMGH = 4;
  localparam int LX   = SCRW - IMGW;
  localparam int LY   = SCRH - IMGH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  step_x = 4'd4;
  logic [3:0]  step_y = 4'd1;
  logic        tvalid = 1'b0;
  logic        tready = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;

  logic [12:0] addw, subw, addh, subh;
  logic [15:0] fcnt;
  logic        serr;
  logic [12:0] addw3, subw3, addh3, subh3;
  logic [15:0] fcnt3;
  logic        serr3;

  always #5 clk = ~clk;

  video_img_pos_ctrl #(.SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH), .FRAME_DIV(1)) dut (
    .clk(clk), .rst(rst), .en(en), .step_x(step_x), .step_y(step_y),
    .snp_tvalid(tvalid), .snp_tready(tready), .snp_tuser(tuser), .snp_tlast(tlast),
    .addw(addw), .subw(subw), .addh(addh), .subh(subh), .frame_cnt(fcnt), .sync_err(serr)
  );

  video_img_pos_ctrl #(.SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH), .FRAME_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .step_x(step_x), .step_y(step_y),
    .snp_tvalid(tvalid), .snp_tready(tready), .snp_tuser(tuser), .snp_tlast(tlast),
    .addw(addw3), .subw(subw3), .addh(addh3), .subh(subh3), .frame_cnt(fcnt3), .sync_err(serr3)
  );

  typedef struct {
    int addw;
    int addh;
    int fc;
  } exp_t;

  typedef struct {
    bit rst;
    bit bp;
    bit en;
    int pix;
    int e_addw;
    int e_addh;
    int e_fc;
    bit chk3;
    int e3_addw;
    int e3_addh;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   serr_cnt = 0;
  logic serr_prev = 1'b0;
  logic rst_s;
  logic [67:0] prev_out;
  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit bp, bit e, int pix, int ax, int ay, int fc,
                              bit c3, int ax3, int ay3);
    vec_t v;
    v.rst = r; v.bp = bp; v.en = e; v.pix = pix;
    v.e_addw = ax; v.e_addh = ay; v.e_fc = fc;
    v.chk3 = c3; v.e3_addw = ax3; v.e3_addh = ay3;
    return v;
  endfunction

  always @(posedge clk) rst_s <= rst;

  // Output monitor: any change of the margins or frame count outside reset
  // must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_s) begin
      prev_out = {addw, addh, subw, subh, fcnt};
    end else if ({addw, addh, subw, subh, fcnt} != prev_out) begin
      if (sb.size() == 0) begin
        check("unexpected_output_change_fc", {16'd0, fcnt}, {16'd0, prev_out[15:0]});
      end else begin
        e_mon = sb.pop_front();
        check("addw", {19'd0, addw}, e_mon.addw);
        check("subw", {19'd0, subw}, LX - e_mon.addw);
        check("addh", {19'd0, addh}, e_mon.addh);
        check("subh", {19'd0, subh}, LY - e_mon.addh);
        check("frame_cnt", {16'd0, fcnt}, e_mon.fc);
      end
      prev_out = {addw, addh, subw, subh, fcnt};
    end
    if (serr === 1'b1) begin
      serr_cnt++;
      if (serr_prev === 1'b1) check("sync_err_width", 32'd2, 32'd1);
    end
    serr_prev = serr;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic u, input logic l);
    tvalid = 1'b1; tready = 1'b1; tuser = u; tlast = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Random non-beat cycles: either tvalid or tready low, markers quiet.
  task automatic gap_cycles();
    int n;
    n = $urandom_range(0, 2);
    repeat (n) begin
      tvalid = 1'($urandom_range(0, 1));
      tready = tvalid ? 1'b0 : 1'($urandom_range(0, 1));
      tuser = 1'b0; tlast = 1'b0;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0; tready = 1'b0;
  endtask

  // Line length is irrelevant to the controller, so lines are kept short.
  task automatic send_frame(input int lines, input int pix, input bit bp, input bit with_sof);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < pix; p++) begin
        if (bp) gap_cycles();
        beat(with_sof && (l == 0) && (p == 0), p == pix - 1);
      end
    end
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addw"}, {19'd0, addw}, 0);
    check({tag, "_subw"}, {19'd0, subw}, LX);
    check({tag, "_addh"}, {19'd0, addh}, 0);
    check({tag, "_subh"}, {19'd0, subh}, LY);
    check({tag, "_fc"}, {16'd0, fcnt}, 0);
    check({tag, "_sync_err"}, {31'd0, serr}, 0);
    check({tag, "_dut3_addw"}, {19'd0, addw3}, 0);
  endtask

  task automatic run_row(input int i);
    vec_t v;
    v = vecs[i];
    if (v.rst) begin
      do_reset();
      check_reset($sformatf("row%0d_reset", i));
    end
    en = v.en;
    sb.push_back('{addw: v.e_addw, addh: v.e_addh, fc: v.e_fc});
    send_frame(SCRH, v.pix, v.bp, 1'b1);
    check($sformatf("row%0d_sb_drained", i), sb.size(), 0);
    if (v.chk3) begin
      check($sformatf("row%0d_div3_addw", i), {19'd0, addw3}, v.e3_addw);
      check($sformatf("row%0d_div3_subw", i), {19'd0, subw3}, LX - v.e3_addw);
      check($sformatf("row%0d_div3_addh", i), {19'd0, addh3}, v.e3_addh);
      check($sformatf("row%0d_div3_subh", i), {19'd0, subh3}, LY - v.e3_addh);
      check($sformatf("row%0d_div3_fc", i), {16'd0, fcnt3}, v.e_fc);
    end
  endtask

  initial begin
    // Clean frames, then bounce on both axes (some frames use 1-pixel lines).
    vecs[0]  = mk(1, 0, 1, 4,  4, 1,  1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 4,  8, 2,  2, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 4, 12, 3,  3, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 16, 4,  4, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 20, 3,  5, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 4, 24, 2,  6, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 4, 28, 1,  7, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1, 4, 32, 0,  8, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 4, 36, 1,  9, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 40, 2, 10, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 4, 44, 3, 11, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 4, 48, 4, 12, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 4, 44, 3, 13, 0, 0, 0);
    // Backpressure: same offsets as the clean run.
    vecs[13] = mk(1, 1, 1, 4,  4, 1,  1, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 4,  8, 2,  2, 0, 0, 0);
    vecs[15] = mk(0, 1, 1, 4, 12, 3,  3, 0, 0, 0);
    // Divide-by-3 instance with motion disabled for frames 4-6.
    vecs[16] = mk(1, 0, 1, 4,  4, 1,  1, 1, 0, 0);
    vecs[17] = mk(0, 0, 1, 4,  8, 2,  2, 1, 0, 0);
    vecs[18] = mk(0, 0, 1, 4, 12, 3,  3, 1, 4, 1);
    vecs[19] = mk(0, 0, 0, 4, 12, 3,  4, 1, 4, 1);
    vecs[20] = mk(0, 0, 0, 4, 12, 3,  5, 1, 4, 1);
    vecs[21] = mk(0, 0, 0, 4, 12, 3,  6, 1, 4, 1);
    vecs[22] = mk(0, 0, 1, 4, 16, 4,  7, 1, 4, 1);
    vecs[23] = mk(0, 0, 1, 4, 20, 3,  8, 1, 4, 1);
    vecs[24] = mk(0, 0, 1, 4, 24, 2,  9, 1, 8, 2);

    idle(2);
    for (int i = 0; i < 16; i++) run_row(i);

    // Glitch: SOF after 3 lines aborts the frame, then the new frame completes.
    send_frame(3, 4, 1'b0, 1'b1);
    check("glitch_partial_fc", {16'd0, fcnt}, 3);
    check("glitch_partial_addw", {19'd0, addw}, 12);
    begin
      int serr_before;
      serr_before = serr_cnt;
      sb.push_back('{addw: 16, addh: 4, fc: 4});
      send_frame(SCRH, 4, 1'b0, 1'b1);
      check("glitch_sync_err_pulses", serr_cnt - serr_before, 1);
      check("glitch_sb_drained", sb.size(), 0);
    end

    // Reset mid-frame, then EOLs without SOF must not count.
    send_frame(2, 4, 1'b0, 1'b1);
    do_reset();
    check_reset("midframe_reset");
    send_frame(SCRH, 4, 1'b0, 1'b0);
    check("no_sof_fc", {16'd0, fcnt}, 0);
    sb.push_back('{addw: 4, addh: 1, fc: 1});
    send_frame(SCRH, 4, 1'b0, 1'b1);
    check("after_reset_sb_drained", sb.size(), 0);

    for (int i = 16; i < 25; i++) run_row(i);

    check("sync_err_total", serr_cnt, 1);
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
